// File: rtl/bram_scan_reader_if.sv
// Pixel-stream bundle between the VGA timing generator, the BRAM image
// buffer and the scan reader. The master modport is the scan reader itself;
// the slave modport is the environment (timing generator plus buffer).
interface bram_scan_reader_if;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        active_in;
  logic        hsync_in;
  logic        vsync_in;
  logic [6:0]  row;
  logic [6:0]  col;
  logic [11:0] rgb_in;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        in_window;

  modport master (
    input  hpos, vpos, active_in, hsync_in, vsync_in, rgb_in,
    output row, col, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, in_window
  );

  modport slave (
    output hpos, vpos, active_in, hsync_in, vsync_in, rgb_in,
    input  row, col, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, in_window
  );
endinterface

// File: rtl/bram_scan_reader.sv
// Read stage for the BRAM image buffer: maps screen coordinates into buffer
// addresses, upscales by 2^SCALE inside a window, and drives the VGA pins
// with syncs delayed to match the buffer's 1-cycle read latency (3 cycles
// total from timing inputs to every output).
// Optional feature: define SCAN_BOUNCE_EN to make the window origin bounce
// around the screen by one pixel per frame; otherwise it is fixed at (X0, Y0).
module bram_scan_reader #(
  parameter int          BUFW       = 64,
  parameter int          BUFH       = 64,
  parameter int          SCALE      = 2,
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter int          X0         = 192,
  parameter int          Y0         = 112,
  parameter logic [11:0] BORDER_RGB = 12'h111
) (
  input  logic               clk,
  input  logic               reset,
  bram_scan_reader_if.master bus
);

  localparam int                 WIN_W   = BUFW << SCALE;
  localparam int                 WIN_H   = BUFH << SCALE;
  localparam logic signed [10:0] WIN_W_S = 11'(WIN_W);
  localparam logic signed [10:0] WIN_H_S = 11'(WIN_H);

  if (WIN_W > H_ACTIVE || WIN_H > V_ACTIVE) begin : g_size_check
    $error("bram_scan_reader: scaled window does not fit the active area");
  end

  logic [9:0] x0;
  logic [9:0] y0;

`ifdef SCAN_BOUNCE_EN
  localparam logic [9:0] X_MAX = 10'(H_ACTIVE - WIN_W);
  localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - WIN_H);

  logic       frame_end;
  logic [9:0] x0_q, x0_d, y0_q, y0_d;
  logic       xdir_q, xdir_d, ydir_q, ydir_d;   // 1 = moving +1, 0 = moving -1

  // Advance one axis by one pixel, reflecting at 0 and lim; returns {dir, pos}.
  // An origin already at a limit is held there while the direction flips.
  function automatic logic [10:0] bounce(input logic [9:0] pos,
                                         input logic       dir,
                                         input logic [9:0] lim);
    logic [9:0] nxt;
    if (dir) begin
      if (pos >= lim) return {1'b0, lim};
      nxt = pos + 10'd1;
      return {(nxt < lim), nxt};
    end else begin
      if (pos == 10'd0) return {1'b1, 10'd0};
      nxt = pos - 10'd1;
      return {(nxt == 10'd0), nxt};
    end
  endfunction

  assign frame_end = (bus.hpos == 10'd0) && (bus.vpos == 10'(V_ACTIVE));

  // Origin moves only on the frame-end strobe so a frame never tears.
  always_comb begin
    x0_d   = x0_q;
    xdir_d = xdir_q;
    y0_d   = y0_q;
    ydir_d = ydir_q;
    if (frame_end) begin
      {xdir_d, x0_d} = bounce(x0_q, xdir_q, X_MAX);
      {ydir_d, y0_d} = bounce(y0_q, ydir_q, Y_MAX);
    end
  end

  // Origin and direction state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0_q   <= 10'(X0);
      y0_q   <= 10'(Y0);
      xdir_q <= 1'b1;
      ydir_q <= 1'b1;
    end else begin
      x0_q   <= x0_d;
      y0_q   <= y0_d;
      xdir_q <= xdir_d;
      ydir_q <= ydir_d;
    end
  end

  assign x0 = x0_q;
  assign y0 = y0_q;
`else
  assign x0 = 10'(X0);
  assign y0 = 10'(Y0);
`endif

  // ---- stage 0 -> 1: window test and buffer address ----
  logic signed [10:0] dx_s, dy_s;
  logic               in_x, in_y;
  logic               win_d;
  logic [6:0]         row_q, row_d, col_q, col_d;
  logic               win_p1, act_p1, hs_p1, vs_p1;

  // 11-bit signed offsets keep the range test exact at both screen edges.
  assign dx_s = $signed({1'b0, bus.hpos}) - $signed({1'b0, x0});
  assign dy_s = $signed({1'b0, bus.vpos}) - $signed({1'b0, y0});
  assign in_x = (dx_s >= 11'sd0) && (dx_s < WIN_W_S);
  assign in_y = (dy_s >= 11'sd0) && (dy_s < WIN_H_S);

  // Compute the next buffer address; outside the window it holds.
  always_comb begin
    win_d = bus.active_in && in_x && in_y;
    row_d = row_q;
    col_d = col_q;
    if (win_d) begin
      col_d = 7'(dx_s[9:0] >> SCALE);
      row_d = 7'(dy_s[9:0] >> SCALE);
    end
  end

  // Register the address and the flags travelling alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q  <= '0;
      col_q  <= '0;
      win_p1 <= 1'b0;
      act_p1 <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      win_p1 <= win_d;
      act_p1 <= bus.active_in;
      hs_p1  <= bus.hsync_in;
      vs_p1  <= bus.vsync_in;
    end
  end

  assign bus.row = row_q;
  assign bus.col = col_q;

  // ---- stage 1 -> 2: buffer read in flight ----
  logic win_p2, act_p2, hs_p2, vs_p2;

  // Flags wait one cycle for the buffer's registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_p2 <= 1'b0;
      act_p2 <= 1'b0;
      hs_p2  <= 1'b0;
      vs_p2  <= 1'b0;
    end else begin
      win_p2 <= win_p1;
      act_p2 <= act_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
    end
  end

  // ---- stage 2 -> 3: pixel select and output registers ----
  logic [11:0] rgb_d, rgb_q;
  logic        win_q, hs_q, vs_q;

  // Buffer pixel inside the window, border colour elsewhere in the visible area.
  always_comb begin
    rgb_d = 12'h000;
    if (win_p2)      rgb_d = bus.rgb_in;
    else if (act_p2) rgb_d = BORDER_RGB;
  end

  // Output registers; async reset blanks the pins immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= '0;
      win_q <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      win_q <= win_p2;
      hs_q  <= hs_p2;
      vs_q  <= vs_p2;
    end
  end

  // Buffer words are BGR with blue in bits 11:8.
  assign {bus.vga_b, bus.vga_g, bus.vga_r} = rgb_q;
  assign bus.in_window = win_q;
  assign bus.vga_hsync = hs_q;
  assign bus.vga_vsync = vs_q;

endmodule

// File: tb/tb_bram_scan_reader.sv
// Bench for bram_scan_reader: a behavioural buffer answers row/col reads one
// cycle later, and a scoreboard queue holds the expected pin values for each
// driven pixel until they emerge three cycles later.
module tb_bram_scan_reader;

  localparam int WX0 = 192;
  localparam int WY0 = 112;
  localparam int WW  = 256;
  localparam int WH  = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bram_scan_reader_if bus();

  bram_scan_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Buffer contents: distinct per row/col, with (0,0) holding 12'hF00.
  function automatic logic [11:0] mem(input logic [6:0] r, input logic [6:0] c);
    return {r[5:0], c[5:0]} ^ 12'hF00;
  endfunction

  // Registered buffer read.
  always @(posedge clk) bus.rgb_in <= mem(bus.row, bus.col);

  typedef struct packed {
    logic [11:0] rgb;
    logic        win;
    logic        hs;
    logic        vs;
  } out_t;

  out_t       sb[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  logic [6:0] mrow, mcol;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pins"}, {1'b0, bus.vga_b, bus.vga_g, bus.vga_r, bus.in_window,
                           bus.vga_hsync, bus.vga_vsync}, 16'h0000);
    check({tag, "_addr"}, {2'b00, bus.row, bus.col}, 16'h0000);
  endtask

  // Drive one pixel, predict its outputs, and compare the pixel from 3 cycles ago.
  task automatic step(input int h, input int v, input logic act, input logic hs, input logic vs);
    logic w;
    out_t e, old;
    @(negedge clk);
    bus.hpos      = 10'(h);
    bus.vpos      = 10'(v);
    bus.active_in = act;
    bus.hsync_in  = hs;
    bus.vsync_in  = vs;
    w = act && (h >= WX0) && (h < WX0 + WW) && (v >= WY0) && (v < WY0 + WH);
    if (w) begin
      mcol = 7'((h - WX0) / 4);
      mrow = 7'((v - WY0) / 4);
    end
    e.rgb = w ? mem(mrow, mcol) : (act ? 12'h111 : 12'h000);
    e.win = w;
    e.hs  = hs;
    e.vs  = vs;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check($sformatf("addr h=%0d v=%0d", h, v), {2'b00, bus.row, bus.col}, {2'b00, mrow, mcol});
    if (sb.size() == 3) begin
      old = sb.pop_front();
      check("pixel", {1'b0, bus.vga_b, bus.vga_g, bus.vga_r, bus.in_window,
                      bus.vga_hsync, bus.vga_vsync}, {1'b0, old});
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.hpos      = '0;
    bus.vpos      = '0;
    bus.active_in = 1'b0;
    bus.hsync_in  = 1'b0;
    bus.vsync_in  = 1'b0;
    mrow          = '0;
    mcol          = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // First window pixel, then the scale mapping along the top line.
    for (int h = 192; h <= 197; h++) step(h, 112, 1'b1, 1'b0, 1'b0);
    for (int h = 188; h <= 191; h++) step(h, 112, 1'b1, 1'b0, 1'b0);
    for (int h = 444; h <= 450; h++) step(h, 113, 1'b1, 1'b0, 1'b0);

    // Bottom-right corner and the line just below the window.
    for (int h = 446; h <= 449; h++) step(h, 367, 1'b1, 1'b0, 1'b0);
    for (int h = 446; h <= 449; h++) step(h, 368, 1'b1, 1'b0, 1'b0);
    step(300, 111, 1'b1, 1'b0, 1'b0);

    // Blanking with sync pulses, including over window coordinates.
    step(300, 200, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(300 + i, 200, 1'b0, 1'b1, 1'b0);
    step(310, 200, 1'b0, 1'b0, 1'b1);
    step(311, 200, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(320 + i, 200, 1'b0, 1'b0, 1'b0);

    // Async reset mid-line, between clock edges.
    for (int h = 250; h <= 255; h++) step(h, 150, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    mrow = '0;
    mcol = '0;
    for (int h = 260; h <= 265; h++) step(h, 150, 1'b1, 1'b0, 1'b0);

`ifdef SCAN_BOUNCE_EN
    step(0, 480, 1'b0, 1'b0, 1'b0);
    check("x0_after_strobe", 16'(dut.x0_q), 16'd193);
    check("y0_after_strobe", 16'(dut.y0_q), 16'd113);
    @(negedge clk);
    force dut.x0_q = 10'd384;
    #1;
    release dut.x0_q;
    step(0, 480, 1'b0, 1'b0, 1'b0);
    check("x0_at_limit", 16'(dut.x0_q), 16'd384);
    check("dx_reversed", 16'(dut.xdir_q), 16'd0);
    step(0, 480, 1'b0, 1'b0, 1'b0);
    check("x0_back", 16'(dut.x0_q), 16'd383);
`else
    // Ten frame-end strobes must leave the window where it was.
    for (int i = 0; i < 10; i++) step(0, 480, 1'b0, 1'b0, 1'b0);
    for (int h = 190; h <= 194; h++) step(h, 112, 1'b1, 1'b0, 1'b0);
    step(200, 111, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_scan_reader.md
Name: bram_scan_reader

Overview:
- Downstream read stage for the 64x64x12-bit BRAM image buffer.
- Consumes pixel coordinates and syncs from the VGA timing generator and drives the buffer's row/col address.
- Takes the buffer's registered rgb back, upscales the image by 2^SCALE, places it in a window on screen, and drives the VGA pins.
- Pipelines the syncs so they stay aligned with the buffer's 1-cycle read latency.

Parameters:
- BUFW, 64, buffer width in pixels (power of 2, ≤128).
- BUFH, 64, buffer height in pixels (power of 2, ≤128).
- SCALE, 2, log2 of the upscale factor. Window is (BUFW<<SCALE) x (BUFH<<SCALE).
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- X0, 192, window left edge after reset.
- Y0, 112, window top edge after reset.
- BORDER_RGB, 12'h111, colour for active pixels outside the window.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- hpos  in  10  current pixel x from the timing generator.
- vpos  in  10  current line y from the timing generator.
- active_in  in  1  visible-region flag.
- hsync_in  in  1  horizontal sync, already polarity-correct.
- vsync_in  in  1  vertical sync, already polarity-correct.
- row  out  7  buffer row address (registered).
- col  out  7  buffer col address (registered).
- rgb_in  in  12  buffer read data; valid 1 cycle after row/col.
- vga_r  out  4  red output (registered).
- vga_g  out  4  green output (registered).
- vga_b  out  4  blue output (registered).
- vga_hsync  out  1  delayed hsync.
- vga_vsync  out  1  delayed vsync.
- in_window  out  1  high when the displayed pixel is sourced from the buffer.

Behaviour:
- Reset (async, active-high) clears:
  - row, col, vga_r/g/b, in_window, all pipeline stages → 0.
  - vga_hsync, vga_vsync → 0.
  - Window origin → (X0, Y0).
- Stage 1, cycle N+1:
  - win = active_in && hpos in [x0, x0+(BUFW<<SCALE)) && vpos in [y0, y0+(BUFH<<SCALE)).
  - If win: col <= (hpos-x0)>>SCALE and row <= (vpos-y0)>>SCALE, truncated to 7 bits. Otherwise row and col hold their previous value.
  - win, active_in, hsync_in, vsync_in are registered alongside.
- Stage 2, cycle N+2: buffer presents rgb_in. Flags shift one more stage.
- Stage 3, cycle N+3: outputs registered.
  - win: {vga_b,vga_g,vga_r} <= rgb_in (buffer data is BGR, bits 11:8 = B).
  - active and not win: BORDER_RGB.
  - Inactive: 0.
- Latency: 3 cycles from hpos/vpos/syncs to every output, including vga_hsync, vga_vsync and in_window. All outputs shift together.
- Subtraction uses 11-bit signed intermediates. The comparisons must be correct at x0=0 and at x0+(BUFW<<SCALE)=H_ACTIVE.
- Window origin (x0, y0) changes only on the frame-end strobe (hpos==0 && vpos==V_ACTIVE, one cycle per frame). It is never mid-frame, so no tearing.
- No stall or handshake: the pixel stream is continuous. Reset asserted mid-frame blanks the output within 0 cycles (async). The pipeline refills 3 cycles after release.
- Elaboration check: (BUFW<<SCALE) ≤ H_ACTIVE and (BUFH<<SCALE) ≤ V_ACTIVE. Otherwise $error.

Optional Feature:
- Macro: SCAN_BOUNCE_EN.
- Defined:
  - x0 and y0 each move 1 pixel per frame-end strobe with direction bits dx, dy. dx=+1, dy=+1 at reset.
  - When x0 reaches H_ACTIVE-(BUFW<<SCALE), dx becomes -1 on that same update. When x0 reaches 0, dx becomes +1. y0/dy use V_ACTIVE and BUFH the same way.
  - x0 never leaves [0, H_ACTIVE-(BUFW<<SCALE)].
- Not defined: x0=X0 and y0=Y0 are constants. No direction registers.

Test Plan:
- Reset release, hpos=192, vpos=112, active_in=1:
  - row=0, col=0 at N+1.
  - rgb_in=12'hF00 at N+2 → vga_b=F, vga_g=0, vga_r=0, in_window=1 at N+3.
- Scale mapping with SCALE=2, vpos=112:
  - hpos 192..195 → col=0; hpos 196 → col=1.
  - hpos 447 → col=63; hpos 448 → in_window=0 and RGB=BORDER_RGB 3 cycles later.
- Blanking: active_in=0 anywhere → RGB=0, in_window=0. A hsync_in pulse at cycle K appears on vga_hsync at K+3 with identical width.
- Window corner: vpos=367, hpos=447 → row=63, col=63. vpos=368 → in_window=0.
- Async reset mid-line: assert reset between clock edges → all outputs 0 immediately, before the next edge. Deassert → first valid pixel 3 cycles later.
- SCAN_BOUNCE_EN: after 1 frame-end strobe x0=193, y0=113. Force x0=384, apply 1 strobe → x0 stays in range, dx=-1, next strobe x0=383. Without the macro x0 stays 192 across 10 frames.
